// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit, one radix-2 step per cycle.
// Ports: clk, reset (async, active-high), start, flush, op[2:0], a, b in;
//        busy, done (1-cycle pulse), result, dz (divide-by-zero, valid with done) out.
// Define MULDIV_DIV_EN to build the divide/remainder datapath; without it ops 100-111
// finish one cycle after start with result 0 and dz 0.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int FAST_SPECIAL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             dz
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, nextState;
  logic [CW-1:0] count;
  logic [2:0] opQ;
  logic [WIDTH-1:0] hi, lo, mcand, specQ, resultQ;
  logic negQ, specialQ, dzQ;
  logic isDiv, aSigned, bSigned, aNeg, bNeg, bZero, isSpecial, fast, accept;
  logic [WIDTH-1:0] magA, magB, specVal, calcVal;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] step, prod;
  assign isDiv = op[2];
  assign aSigned = isDiv ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
  assign bSigned = isDiv ? ~op[0] : (op[1:0] == 2'b01);
  assign aNeg = aSigned & a[WIDTH-1];
  assign bNeg = bSigned & b[WIDTH-1];
  assign magA = aNeg ? -a : a;
  assign magB = bNeg ? -b : b;
  assign accept = (state == IDLE) & start & ~flush;
  // shift-add step: add multiplicand when the multiplier LSB is set, then shift {hi,lo} right
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
`ifdef MULDIV_DIV_EN
  logic ovf;
  logic [WIDTH:0] tmp, diff;
  assign bZero = isDiv & (b == '0);
  assign ovf = isDiv & ~op[0] & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (&b);
  assign isSpecial = bZero | ovf;
  assign specVal = bZero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
  // restoring step: hi is the partial remainder, lo shifts dividend bits out and quotient bits in
  assign tmp = {hi, lo[WIDTH-1]};
  assign diff = tmp - {1'b0, mcand};
  assign step = !opQ[2] ? {sum, lo[WIDTH-1:1]}
              : diff[WIDTH] ? {tmp[WIDTH-1:0], lo[WIDTH-2:0], 1'b0}
              : {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
`else
  assign bZero = 1'b0;
  assign isSpecial = isDiv;
  assign specVal = '0;
  assign step = {sum, lo[WIDTH-1:1]};
`endif
  // without a divider every divide op takes the one-cycle special path
  assign fast = isSpecial & ((FAST_SPECIAL != 0) | ~DivEn);
  assign prod = negQ ? -{hi, lo} : {hi, lo};
  assign calcVal = opQ[2] ? (negQ ? -(opQ[1] ? hi : lo) : (opQ[1] ? hi : lo))
                 : (opQ[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign dz = done & dzQ;
  assign result = done ? (specialQ ? specQ : calcVal) : resultQ;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    if (flush) nextState = IDLE;
    else if (state == IDLE) nextState = !start ? IDLE : fast ? DONE : CALC;
    else if (state == CALC) nextState = (count == CW'(1)) ? DONE : CALC;
    else nextState = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      opQ <= '0;
      hi <= '0;
      lo <= '0;
      mcand <= '0;
      specQ <= '0;
      resultQ <= '0;
      negQ <= 1'b0;
      specialQ <= 1'b0;
      dzQ <= 1'b0;
    end else if (accept) begin
      count <= CW'(WIDTH);
      opQ <= op;
      hi <= '0;
      lo <= magA;
      mcand <= magB;
      specQ <= specVal;
      // remainder takes the dividend's sign; everything else the xor of operand signs
      negQ <= (isDiv & op[1]) ? aNeg : aNeg ^ bNeg;
      specialQ <= isSpecial;
      dzQ <= bZero;
    end else if (state == CALC && !flush) begin
      count <= count - CW'(1);
      {hi, lo} <= step;
    end else if (done && !flush) resultQ <= result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH=32) against a plain-arithmetic model.
module tb_muldiv_unit;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, dz;
  logic [31:0] result;
  int checks = 0, fails = 0;
  int n;
  bit sawDone;
  logic [31:0] lastExp = '0;
  logic [2:0] ro;
  logic [31:0] rx, ry;
`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif
  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .dz(dz)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic d, output int lat);
    int sx, sy;
    longint ps, psu;
    logic [63:0] pu;
    bit ovf;
    sx = x;
    sy = y;
    ps = longint'(sx) * longint'(sy);
    psu = longint'(sx) * longint'({32'h0, y});
    pu = {32'h0, x} * {32'h0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF) && !o[0];
    d = o[2] && (y == 0);
    lat = 33;
    r = '0;
    case (o)
      3'd0: r = pu[31:0];
      3'd1: r = ps[63:32];
      3'd2: r = psu[63:32];
      3'd3: r = pu[63:32];
      default: begin
        if (d || ovf) lat = 1;
        if (d) r = o[1] ? x : 32'hFFFF_FFFF;
        else if (ovf) r = o[1] ? 32'h0 : x;
        else case (o[1:0])
          2'd0: r = sx / sy;
          2'd1: r = x / y;
          2'd2: r = sx % sy;
          default: r = x % y;
        endcase
        if (!DivEn) begin
          r = '0;
          d = 1'b0;
          lat = 1;
        end
      end
    endcase
  endfunction
  // called at a negedge; returns at the negedge after the done pulse
  task automatic runOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic ed;
    int lat, k;
    model(o, x, y, er, ed, lat);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      k++;
      if (k == 1 && lat > 1) check("busy in calc", busy, 1);
    end while (!done && k < 100);
    check($sformatf("latency op%0d a=%h b=%h", o, x, y), k, lat);
    check($sformatf("result op%0d a=%h b=%h", o, x, y), result, er);
    check($sformatf("dz op%0d", o), dz, ed);
    lastExp = er;
    @(negedge clk);
    check("done one cycle", done, 0);
    check("busy after done", busy, 0);
  endtask
  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dz", dz, 0);
    check("reset result", result, 0);
    reset = 1'b0;
    runOp(3'd0, 32'd7, 32'hFFFF_FFFD);
    check("mul 7*-3", result, 32'hFFFF_FFEB);
    runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu max", result, 32'hFFFF_FFFE);
    runOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulh -1*-1", result, 32'h0);
    runOp(3'd2, 32'hFFFF_FFFE, 32'd3);
    runOp(3'd1, 32'h8000_0000, 32'h8000_0000);
    runOp(3'd4, 32'hFFFF_FFF9, 32'd2);
    runOp(3'd6, 32'hFFFF_FFF9, 32'd2);
    runOp(3'd5, 32'd100, 32'd0);
    runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp(3'd7, 32'd5, 32'd0);
    runOp(3'd6, 32'd7, 32'hFFFF_FFFE);
    runOp(3'd4, 32'd0, 32'd0);
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(7))
        0: ry = 32'h0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = $urandom_range(15);
        default: ;
      endcase
      runOp(ro, rx, ry);
    end
    // a second start while busy must not disturb the operation in flight
    op = 3'd0;
    a = 32'd11;
    b = 32'd13;
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 5) begin
        op = 3'd3;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        start = 1'b1;
      end
    end while (!done && n < 100);
    check("busy start latency", n, 33);
    check("busy start result", result, 143);
    lastExp = 32'd143;
    @(negedge clk);
    // flush ten cycles into a multiply
    op = 3'd0;
    a = 32'd5;
    b = 32'd6;
    start = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", busy, 0);
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    check("flush no done", sawDone, 0);
    check("flush result held", result, lastExp);
    // start and flush together in IDLE: start is dropped
    op = 3'd0;
    a = 32'd2;
    b = 32'd2;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("start+flush busy", busy, 0);
    sawDone = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    check("start+flush no done", sawDone, 0);
    // asynchronous reset mid-calculation
    op = 3'd0;
    a = 32'd3;
    b = 32'd4;
    start = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset busy", busy, 0);
    check("async reset done", done, 0);
    check("async reset result", result, 0);
    @(negedge clk);
    reset = 1'b0;
    lastExp = '0;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    check("no done after reset", sawDone, 0);
    check("result after reset", result, lastExp);
    runOp(3'd5, 32'd9, 32'd3);
    runOp(3'd0, 32'd6, 32'd7);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
